// File: rtl/id_issue_ctrl.sv
//==============================================================================
// id_issue_ctrl : decode-to-execute issue slot with RAW/WAW scoreboard
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module id_issue_ctrl #(
  parameter  int NUM_REGS = 16,
  parameter  int OPC_W    = 8,
  parameter  int CNT_W    = 16,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_writes_rd,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_writes_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t         state_q, state_d;
  logic [OPC_W-1:0]    ex_opcode_q, ex_opcode_d;
  logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
  logic                ex_writes_rd_q, ex_writes_rd_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic                hazard;
  logic                slot_free;
  logic                issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_EMPTY;
      ex_opcode_q    <= '0;
      ex_rd_q        <= '0;
      ex_writes_rd_q <= 1'b0;
      pending_q      <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      ex_opcode_q    <= ex_opcode_d;
      ex_rd_q        <= ex_rd_d;
      ex_writes_rd_q <= ex_writes_rd_d;
      pending_q      <= pending_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // A writeback in the same cycle already resolves the dependency.
  always_comb begin
    wb_mask  = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
    pend_eff = pending_q & ~wb_mask;
    hazard   = (id_uses_rs1  && (id_rs1 != '0) && pend_eff[id_rs1])
             | (id_uses_rs2  && (id_rs2 != '0) && pend_eff[id_rs2])
             | (id_writes_rd && (id_rd  != '0) && pend_eff[id_rd]);
  end

  assign ex_valid  = (state_q == S_FULL);
  assign slot_free = !ex_valid || ex_ready;
  assign id_ready  = !hazard && slot_free && !flush;
  assign issue     = id_valid && id_ready;

  always_comb begin
    state_d        = state_q;
    ex_opcode_d    = ex_opcode_q;
    ex_rd_d        = ex_rd_q;
    ex_writes_rd_d = ex_writes_rd_q;

    // Flush wins over any handshake; issue is already blocked during flush.
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (issue) state_d = S_FULL;
        S_FULL:  if (ex_ready) state_d = issue ? S_FULL : S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end

    if (issue) begin
      ex_opcode_d    = id_opcode;
      ex_rd_d        = id_rd;
      ex_writes_rd_d = id_writes_rd;
    end
  end

  // Ordered so a same-cycle set beats any clear on the same register.
  always_comb begin
    pending_d = pending_q & ~wb_mask;
    if (flush && ex_valid && ex_writes_rd_q)
      pending_d[ex_rd_q] = 1'b0;
    if (issue && id_writes_rd && (id_rd != '0))
      pending_d[id_rd] = 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign ex_opcode    = ex_opcode_q;
  assign ex_rd        = ex_rd_q;
  assign ex_writes_rd = ex_writes_rd_q;
  assign stall_cnt    = stall_cnt_q;
  assign busy         = ex_valid || (|pending_q);

endmodule

`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
//==============================================================================
// tb_id_issue_ctrl : directed self-checking bench for id_issue_ctrl
// Revision 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_issue_ctrl;

  localparam int NUM_REGS = 16;
  localparam int OPC_W    = 8;
  localparam int CNT_W    = 16;
  localparam int REG_AW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic              id_ready;
  logic [OPC_W-1:0]  id_opcode;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic              ex_valid, ex_ready;
  logic [OPC_W-1:0]  ex_opcode;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_writes_rd;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              flush;
  logic              busy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  id_issue_ctrl #(.NUM_REGS(NUM_REGS), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_writes_rd(ex_writes_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_writes_rd = 1'b0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic drive_op(input logic [7:0] opc, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [3:0] rd, input logic u1, input logic u2, input logic w);
    id_valid = 1'b1; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_writes_rd = w;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    n_total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %b want 0", ex_valid); else n_pass++;
    n_total++; if (ex_opcode !== 8'h00) $display("FAIL reset_ex_opcode got %h want 00", ex_opcode); else n_pass++;
    n_total++; if (stall_cnt !== 16'h0000) $display("FAIL reset_stall_cnt got %h want 0000", stall_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready got %b want 1", id_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw_hazard();
    drive_op(8'h11, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
    #1;
    n_total++; if (id_ready !== 1'b1) $display("FAIL raw_first_ready got %b want 1", id_ready); else n_pass++;
    tick();
    drive_op(8'h22, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_total++; if (id_ready !== 1'b0) $display("FAIL raw_hazard_ready got %b want 0", id_ready); else n_pass++;
    tick();
    tick();
    n_total++; if (stall_cnt !== 16'd2) $display("FAIL raw_stall_cnt got %0d want 2", stall_cnt); else n_pass++;
    wb_valid = 1'b1; wb_rd = 4'd3;
    #1;
    n_total++; if (id_ready !== 1'b1) $display("FAIL raw_wb_bypass_ready got %b want 1", id_ready); else n_pass++;
    tick();
    n_total++; if (ex_opcode !== 8'h22 || ex_valid !== 1'b1)
      $display("FAIL raw_issue_after_wb got op=%h v=%b want op=22 v=1", ex_opcode, ex_valid); else n_pass++;
    n_total++; if (stall_cnt !== 16'd2) $display("FAIL raw_stall_hold got %0d want 2", stall_cnt); else n_pass++;
    idle();
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL raw_drain_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    drive_op(8'h33, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b1);
    tick();
    ex_ready = 1'b0;
    drive_op(8'h44, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_total++; if (id_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", id_ready); else n_pass++;
    tick();
    tick();
    n_total++; if (ex_opcode !== 8'h33 || ex_valid !== 1'b1)
      $display("FAIL bp_hold got op=%h v=%b want op=33 v=1", ex_opcode, ex_valid); else n_pass++;
    n_total++; if (stall_cnt !== 16'd4) $display("FAIL bp_stall_cnt got %0d want 4", stall_cnt); else n_pass++;
    ex_ready = 1'b1;
    #1;
    n_total++; if (id_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", id_ready); else n_pass++;
    tick();
    n_total++; if (ex_opcode !== 8'h44) $display("FAIL bp_next_op got %h want 44", ex_opcode); else n_pass++;
    idle();
    wb_valid = 1'b1; wb_rd = 4'd6;
    tick();
    idle();
    n_total++; if (dut.pending_q !== 16'h0000) $display("FAIL bp_pending_clear got %h want 0000", dut.pending_q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] rds [3];
    rds[0] = 4'd1; rds[1] = 4'd2; rds[2] = 4'd4;
    for (int i = 0; i < 3; i++) begin
      drive_op(8'h60 + 8'(i), 4'd0, 4'd0, rds[i], 1'b0, 1'b0, 1'b1);
      #1;
      n_total++; if (id_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %b want 1", i, id_ready); else n_pass++;
      tick();
      n_total++; if (ex_rd !== rds[i]) $display("FAIL b2b_ex_rd_%0d got %0d want %0d", i, ex_rd, rds[i]); else n_pass++;
    end
    n_total++; if (dut.pending_q !== 16'h0016) $display("FAIL b2b_pending got %h want 0016", dut.pending_q); else n_pass++;
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_rd = rds[i];
      tick();
    end
    idle();
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_after_wb got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reg_zero();
    drive_op(8'h70, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (dut.pending_q !== 16'h0000) $display("FAIL r0_pending got %h want 0000", dut.pending_q); else n_pass++;
    drive_op(8'h71, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    #1;
    n_total++; if (id_ready !== 1'b1) $display("FAIL r0_read_ready got %b want 1", id_ready); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 16'd4) $display("FAIL r0_no_stall got %0d want 4", stall_cnt); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive_op(8'h55, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (dut.pending_q !== 16'h0020) $display("FAIL flush_pre_pending got %h want 0020", dut.pending_q); else n_pass++;
    ex_ready = 1'b0; flush = 1'b1;
    drive_op(8'h56, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_total++; if (id_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", id_ready); else n_pass++;
    tick();
    n_total++; if (ex_valid !== 1'b0) $display("FAIL flush_ex_valid got %b want 0", ex_valid); else n_pass++;
    n_total++; if (dut.pending_q !== 16'h0000) $display("FAIL flush_pending got %h want 0000", dut.pending_q); else n_pass++;
    n_total++; if (stall_cnt !== 16'd4) $display("FAIL flush_no_count got %0d want 4", stall_cnt); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_saturate_and_reset();
    drive_op(8'h77, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1);
    tick();
    drive_op(8'h78, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_stall_cnt got %h want FFFF", stall_cnt); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL sat_busy got %b want 1", busy); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (stall_cnt !== 16'h0000) $display("FAIL async_rst_stall_cnt got %h want 0000", stall_cnt); else n_pass++;
    n_total++; if (busy !== 1'b0 || ex_valid !== 1'b0)
      $display("FAIL async_rst_busy got busy=%b v=%b want 0 0", busy, ex_valid); else n_pass++;
    n_total++; if (ex_opcode !== 8'h00 || ex_rd !== 4'd0 || ex_writes_rd !== 1'b0)
      $display("FAIL async_rst_ex got op=%h rd=%0d w=%b want 00 0 0", ex_opcode, ex_rd, ex_writes_rd); else n_pass++;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_backpressure();
    test_back_to_back();
    test_reg_zero();
    test_flush();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
